// File: rtl/module_iram_loader_if.sv
// Byte-stream input, IRAM write port, PC load port and status of the IRAM loader.
// Handshake: a byte moves only on a rising clk edge where in_valid && in_ready;
// the source holds in_data stable with in_valid high until that edge, and in_valid may drop at any time between transfers.
interface module_iram_loader_if #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [WORD_SIZE-1:0]  in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_SIZE-1:0]  mem_data;
  logic                  cpu_hlt;
  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] pc_addr;
  logic                  busy;
  logic                  error;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_wr_en, mem_addr, mem_data,
    output cpu_hlt, pc_load, pc_addr, busy, error
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_wr_en, mem_addr, mem_data,
    input  cpu_hlt, pc_load, pc_addr, busy, error
  );
endinterface

// File: rtl/module_iram_loader.sv
// Fills IRAM from a LEN/ADDR/data byte frame, halting the CPU and requesting a PC load at the end.
// Define IRAM_LOADER_CSUM_EN to add a trailing checksum byte that gates the PC load and drives error.
module module_iram_loader #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  module_iram_loader_if.master   bus,
  output logic [2:0]             o_dbg_state
);

`ifdef IRAM_LOADER_CSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, GET_ADDR = 3'd1, GET_DATA = 3'd2, GET_CSUM = 3'd3, DONE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, GET_ADDR = 3'd1, GET_DATA = 3'd2, DONE = 3'd4
  } state_t;
`endif

  state_t                r_state;
  state_t                w_next;
  logic [WORD_SIZE-1:0]  r_rem;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] r_pc_addr;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_SIZE-1:0]  r_data;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_error;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_last   = (r_rem == WORD_SIZE'(1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_accept && (bus.in_data != '0)) w_next = GET_ADDR;
      GET_ADDR: if (w_accept) w_next = GET_DATA;
`ifdef IRAM_LOADER_CSUM_EN
      GET_DATA: if (w_accept && w_last) w_next = GET_CSUM;
      GET_CSUM: if (w_accept) w_next = DONE;
`else
      GET_DATA: if (w_accept && w_last) w_next = DONE;
`endif
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Write strobe is registered so it lands exactly one cycle after the data byte is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem     <= '0;
      r_ptr     <= '0;
      r_pc_addr <= '0;
      r_wr_en   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE: if (w_accept && (bus.in_data != '0)) r_rem <= bus.in_data;
        GET_ADDR: if (w_accept) begin
          r_ptr     <= ADDR_WIDTH'(bus.in_data);
          r_pc_addr <= ADDR_WIDTH'(bus.in_data);
        end
        GET_DATA: if (w_accept) begin
          r_wr_en <= 1'b1;
          r_addr  <= r_ptr;
          r_data  <= bus.in_data;
          r_ptr   <= r_ptr + ADDR_WIDTH'(1);
          r_rem   <= r_rem - WORD_SIZE'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef IRAM_LOADER_CSUM_EN
  logic [WORD_SIZE-1:0] r_sum;
  logic                 r_error;

  // Running sum covers LEN, ADDR and every data byte; a new nonzero LEN restarts it and clears error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum   <= '0;
      r_error <= 1'b0;
    end else if (w_accept) begin
      case (r_state)
        IDLE: if (bus.in_data != '0) begin
          r_sum   <= bus.in_data;
          r_error <= 1'b0;
        end
        GET_ADDR, GET_DATA: r_sum <= r_sum + bus.in_data;
        GET_CSUM: if (bus.in_data != r_sum) r_error <= 1'b1;
        default: ;
      endcase
    end
  end

  assign w_error = r_error;
`else
  assign w_error = 1'b0;
`endif

  assign bus.in_ready  = (r_state != DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.cpu_hlt   = (r_state != IDLE);
  assign bus.pc_load   = (r_state == DONE) & ~w_error;
  assign bus.pc_addr   = r_pc_addr;
  assign bus.mem_wr_en = r_wr_en;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_data  = r_data;
  assign bus.error     = w_error;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_module_iram_loader.sv
// Directed bench for module_iram_loader; frames with/without checksum follow IRAM_LOADER_CSUM_EN.
module tb_module_iram_loader;
  localparam int W = 8;
  localparam int A = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  module_iram_loader_if #(.WORD_SIZE(W), .ADDR_WIDTH(A)) bus ();

  module_iram_loader #(.WORD_SIZE(W), .ADDR_WIDTH(A)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [A+W-1:0] exp_q[$];
  logic [A-1:0]   pc_q[$];
  logic [W-1:0]   frame_d[0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe and PC load pops the oldest expectation.
  always @(negedge clk) begin
    if (bus.mem_wr_en === 1'b1) begin
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("write_addr_data", 32'({bus.mem_addr, bus.mem_data}), 32'(exp_q.pop_front()));
    end
    if (bus.pc_load === 1'b1) begin
      check("pc_load_expected", 32'(pc_q.size() != 0), 32'd1);
      if (pc_q.size() != 0) check("pc_addr", 32'(bus.pc_addr), 32'(pc_q.pop_front()));
    end
  end

  task automatic send_byte(input logic [W-1:0] b, input int gap, output int waits);
    waits = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) check("ready_timeout", 32'(waits), 32'd0);
    else @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] len, input logic [A-1:0] addr, input bit bad_csum,
                            input bit chk_end, input int len_gap, output int len_waits);
    int           w;
    logic [W-1:0] sum;
    logic [A-1:0] a;
    bit           good;
    good = 1'b1;
`ifdef IRAM_LOADER_CSUM_EN
    good = !bad_csum;
`endif
    if (good) pc_q.push_back(addr);
    send_byte(len, len_gap, len_waits);
    if (chk_end) begin
      @(negedge clk);
      check("hlt_after_len", 32'(bus.cpu_hlt), 32'd1);
      check("busy_after_len", 32'(bus.busy), 32'd1);
    end
    sum = len + W'(addr);
    send_byte(W'(addr), $urandom_range(0, 2), w);
    for (int i = 0; i < int'(len); i++) begin
      a = addr + A'(i);
      exp_q.push_back({a, frame_d[i]});
      sum = sum + frame_d[i];
      send_byte(frame_d[i], $urandom_range(0, 3), w);
    end
`ifdef IRAM_LOADER_CSUM_EN
    send_byte(bad_csum ? (sum ^ 8'h01) : sum, $urandom_range(0, 2), w);
`endif
    if (chk_end) begin
      @(negedge clk);
      check("done_ready", 32'(bus.in_ready), 32'd0);
      check("done_busy", 32'(bus.busy), 32'd1);
      check("done_hlt", 32'(bus.cpu_hlt), 32'd1);
      check("done_pc_load", 32'(bus.pc_load), 32'(good));
      @(negedge clk);
      check("idle_ready", 32'(bus.in_ready), 32'd1);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_hlt", 32'(bus.cpu_hlt), 32'd0);
      check("idle_pc_load", 32'(bus.pc_load), 32'd0);
      check("frame_error", 32'(bus.error), 32'(!good));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int lw;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rst_hlt", 32'(bus.cpu_hlt), 32'd0);
    check("rst_pc_load", 32'(bus.pc_load), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    // Basic load
    frame_d[0] = 8'hAA; frame_d[1] = 8'hBB; frame_d[2] = 8'hCC;
    send_frame(8'h03, 8'h10, 1'b0, 1'b1, 0, lw);

    // Address wrap-around
    frame_d[0] = 8'h01; frame_d[1] = 8'h02; frame_d[2] = 8'h03;
    send_frame(8'h03, 8'hFE, 1'b0, 1'b1, 1, lw);

`ifdef IRAM_LOADER_CSUM_EN
    // Bad checksum, then a good frame clears error
    frame_d[0] = 8'hAA; frame_d[1] = 8'hBB; frame_d[2] = 8'hCC;
    send_frame(8'h03, 8'h10, 1'b1, 1'b1, 0, lw);
    send_frame(8'h03, 8'h20, 1'b0, 1'b1, 0, lw);
`endif

    // Zero length byte is discarded
    send_byte(8'h00, 0, w);
    @(negedge clk);
    check("zero_len_hlt", 32'(bus.cpu_hlt), 32'd0);
    check("zero_len_busy", 32'(bus.busy), 32'd0);
    frame_d[0] = 8'h5A; frame_d[1] = 8'hA5;
    send_frame(8'h02, 8'h30, 1'b0, 1'b1, 0, lw);

    // Back-to-back frames: next LEN is presented during DONE and must wait exactly one cycle
    for (int i = 0; i < 5; i++) frame_d[i] = W'($urandom_range(0, 255));
    send_frame(8'h05, 8'h80, 1'b0, 1'b0, 0, lw);
    frame_d[0] = 8'h11; frame_d[1] = 8'h22;
    send_frame(8'h02, 8'h90, 1'b0, 1'b1, 0, lw);
    check("done_stall_waits", 32'(lw), 32'd1);

    // Random frames with random gaps
    for (int f = 0; f < 3; f++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) frame_d[i] = W'($urandom_range(0, 255));
      send_frame(W'(n), A'($urandom_range(0, 255)), 1'b0, 1'b1, $urandom_range(0, 3), lw);
    end

    // Reset after the second data byte of a 4-word frame
    send_byte(8'h04, 0, w);
    send_byte(8'h40, 0, w);
    frame_d[0] = 8'hC1; frame_d[1] = 8'hC2;
    exp_q.push_back({8'h40, frame_d[0]});
    send_byte(frame_d[0], 1, w);
    exp_q.push_back({8'h41, frame_d[1]});
    send_byte(frame_d[1], 0, w);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_hlt", 32'(bus.cpu_hlt), 32'd0);
    check("midrst_pc_load", 32'(bus.pc_load), 32'd0);
    check("midrst_ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    check("pc_loads_drained", 32'(pc_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
